// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream, writes little-endian words into
// instruction memory, and releases the core reset once the image checksum matches.
module imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] S_HDR_LO = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    logic [2:0]  state;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [7:0]  acc;
    logic [23:0] word_asm;
    logic        xfer;
    logic [15:0] n_new;

    // Ready is a pure function of state so the source never sees back-pressure mid-frame.
    assign in_ready = rst && (state != S_DONE) && (state != S_ERROR);
    assign xfer     = in_valid && in_ready;
    assign n_new    = {in_data, n_lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_HDR_LO;
            n_lo         <= 8'h00;
            n_words      <= 16'h0000;
            byte_idx     <= 2'd0;
            word_idx     <= 16'h0000;
            acc          <= 8'h00;
            word_asm     <= 24'h000000;
            imem_we      <= 1'b0;
            imem_addr    <= 32'h0;
            imem_wdata   <= 32'h0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
            words_loaded <= 16'h0000;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    S_HDR_LO: begin
                        n_lo  <= in_data;
                        state <= S_HDR_HI;
                    end
                    S_HDR_HI: begin
                        n_words <= n_new;
                        if (n_new == 16'h0000) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'b01;
                        end else if ({1'b0, n_new} > DEPTH_LIM) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'b10;
                        end else begin
                            state    <= S_DATA;
                            byte_idx <= 2'd0;
                            word_idx <= 16'h0000;
                            acc      <= 8'h00;
                        end
                    end
                    S_DATA: begin
                        acc      <= acc ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_asm[7:0]   <= in_data;
                            2'd1: word_asm[15:8]  <= in_data;
                            2'd2: word_asm[23:16] <= in_data;
                            default: begin
                                // Top byte completes the word; commit it straight from in_data.
                                imem_we      <= 1'b1;
                                imem_wdata   <= {in_data, word_asm};
                                imem_addr    <= {14'b0, word_idx, 2'b00};
                                word_idx     <= word_idx + 16'd1;
                                words_loaded <= words_loaded + 16'd1;
                                if (word_idx == n_words - 16'd1) begin
                                    state <= S_CHECK;
                                end
                            end
                        endcase
                    end
                    S_CHECK: begin
                        if (in_data == acc) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'b11;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level model predicts the
// memory writes and the final status; a monitor checks every write strobe.
module tb_imem_loader;

    localparam int DEPTH = 256;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q [$];
    wr_t mon_e;
    logic prev_we = 1'b0;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done),
        .error(error), .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard and last one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                check("we_single_cycle", {31'b0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", imem_addr, mon_e.addr);
                    check("wr_data", imem_wdata, mon_e.data);
                end
            end
            prev_we = imem_we;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_core_rst"}, core_rst, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_async");
        check("sb_empty_at_reset", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b1;
        #1 check("in_ready_after_release", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Model works on the frame as a whole: header gives N, payload gives words LSB first.
    task automatic run_frame(input bq_t b, input int maxgap, input int nsend);
        int          n;
        bit          hdr_ok;
        logic [7:0]  x;
        logic [31:0] w;
        wr_t         e;
        int          k;
        logic [15:0] wl_before;
        logic        done_before, err_before;
        n = {b[1], b[0]};
        hdr_ok = (n != 0) && (n <= DEPTH);
        x = 8'h00;
        if (hdr_ok) begin
            for (int wi = 0; wi < n; wi++) begin
                if (2 + 4 * wi + 3 < b.size()) begin
                    w = {b[2+4*wi+3], b[2+4*wi+2], b[2+4*wi+1], b[2+4*wi]};
                    x = x ^ b[2+4*wi] ^ b[2+4*wi+1] ^ b[2+4*wi+2] ^ b[2+4*wi+3];
                    if (2 + 4 * wi + 3 < nsend) begin
                        e.addr = 32'(wi) * 4;
                        e.data = w;
                        exp_q.push_back(e);
                    end
                end
            end
        end
        for (int i = 0; i < nsend; i++) begin
            send_byte(b[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            k = i - 2;
            if (hdr_ok && k >= 0 && k < 4 * n && (k % 4) == 3) begin
                check("we_latency", imem_we, 1);
                check("words_loaded_step", words_loaded, 32'(k / 4 + 1));
            end
        end
        if (nsend != b.size()) return;
        if (n == 0) begin
            check("zero_error", error, 1);
            check("zero_code", err_code, 2'b01);
            check("zero_done", done, 0);
            check("zero_core_rst", core_rst, 1);
        end else if (n > DEPTH) begin
            check("over_error", error, 1);
            check("over_code", err_code, 2'b10);
            check("over_core_rst", core_rst, 1);
        end else if (b[b.size()-1] == x) begin
            check("ok_done", done, 1);
            check("ok_error", error, 0);
            check("ok_code", err_code, 0);
            check("ok_core_rst", core_rst, 0);
            check("ok_words", words_loaded, 32'(n));
        end else begin
            check("bad_error", error, 1);
            check("bad_code", err_code, 2'b11);
            check("bad_done", done, 0);
            check("bad_core_rst", core_rst, 1);
            check("bad_words", words_loaded, 32'(n));
        end
        check("in_ready_final", in_ready, 0);
        wl_before = words_loaded;
        done_before = done;
        err_before = error;
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("sticky_done", done, done_before);
        check("sticky_error", error, err_before);
        check("post_words", words_loaded, wl_before);
        check("sb_drained", exp_q.size(), 0);
    endtask

    function automatic bq_t make_frame(input int n, input logic [7:0] flip);
        bq_t         f;
        logic [7:0]  x;
        logic [31:0] w;
        f = {};
        x = 8'h00;
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                f.push_back(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
        f.push_back(x ^ flip);
        return f;
    endfunction

    initial begin
        bq_t f1, fbad, fz, fo, fr;
        f1   = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        fbad = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        fz   = {8'h00, 8'h00};
        fo   = {8'h01, 8'h01};

        do_reset();
        run_frame(f1, 0, f1.size());
        do_reset();
        run_frame(fz, 0, fz.size());
        do_reset();
        run_frame(fo, 0, fo.size());
        do_reset();
        run_frame(fbad, 0, fbad.size());
        for (int r = 0; r < 4; r++) begin
            do_reset();
            run_frame(f1, 5, f1.size());
        end
        // Abort after five payload bytes: only the first word may ever appear.
        do_reset();
        run_frame(f1, 0, 7);
        do_reset();
        run_frame(f1, 0, f1.size());
        for (int r = 0; r < 8; r++) begin
            do_reset();
            fr = make_frame(int'($urandom_range(8, 1)),
                            ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00);
            run_frame(fr, int'($urandom_range(3, 0)), fr.size());
        end
        do_reset();
        fr = make_frame(DEPTH, 8'h00);
        run_frame(fr, 0, fr.size());
        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader placed upstream of the single-cycle RV32I core. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written sequentially into the instruction-memory write port. The core is held in reset until the whole image has arrived and its checksum has been verified.

## Interface
Parameters:
- DEPTH, 256: instruction-memory capacity in 32-bit words; the maximum accepted image size.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte source has a valid byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer happens when in_valid & in_ready at a rising edge.
- imem_we  output  1  one-cycle write strobe to the instruction memory.
- imem_addr  output  32  byte address of the word being written; always a multiple of 4.
- imem_wdata  output  32  word being written.
- core_rst  output  1  active-high reset for the core; held at 1 until the load succeeds.
- done  output  1  image loaded and verified; sticky.
- error  output  1  load aborted; sticky.
- err_code  output  2  error cause: 01 = size zero, 10 = size above DEPTH, 11 = checksum mismatch; 00 when there is no error.
- words_loaded  output  16  count of words written so far.

## Operation
- Frame format:
  - N_lo, N_hi: 16-bit word count N, little-endian.
  - 4N payload bytes, least significant byte of each word first.
  - One checksum byte equal to the XOR of all 4N payload bytes.
- State machine states: HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR.
- HDR_LO: on a transfer, latch N[7:0] and move to HDR_HI.
- HDR_HI: on a transfer, latch N[15:8], then decide the next state from N:
  - N == 0: go to ERROR with err_code 01.
  - N > DEPTH: go to ERROR with err_code 10.
  - Otherwise: go to DATA with byte index 0, word index 0 and checksum accumulator 0.
- DATA, each transferred byte:
  - Shifted into the word assembly register at byte lane (byte index mod 4).
  - XORed into the checksum accumulator.
- DATA, on the 4th byte of a word:
  - Schedule a write of the assembled word at address word_index*4.
  - Increment word_index.
  - After word N-1, go to CHECK.
- CHECK: on a transfer, compare in_data with the accumulator.
  - Equal: go to DONE.
  - Not equal: go to ERROR with err_code 11.
- DONE: core_rst = 0 and done = 1; in_ready = 0. Stays here until reset.
- ERROR: core_rst = 1 and error = 1; in_ready = 0. Stays here until reset. Words already written are not erased.
- in_ready is 1 in HDR_LO, HDR_HI, DATA and CHECK, 0 in DONE and ERROR, and forced to 0 while rst is low.
- The loader never back-pressures inside a frame; in_ready depends only on state.
- Bytes arriving after DONE or ERROR are not accepted.
- Arithmetic: word_index is 16 bits. imem_addr = {14'b0, word_index, 2'b00}, zero-extended to 32 bits.

## Timing
- Reset values:
  - State: HDR_LO.
  - in_ready = 0 while rst is low.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - core_rst = 1, done = 0, error = 0, err_code = 00, words_loaded = 0.
  - Internal N, indices and accumulator: 0.
- in_ready rises combinationally once rst deasserts; the first byte can be accepted at the first rising edge after release.
- Write latency: imem_we is registered and asserts for exactly one cycle, in the cycle after the handshake of a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle. words_loaded increments in that cycle.
- A back-to-back stream (in_valid held at 1) produces one write every 4 cycles with no gaps.
- DONE/ERROR entry: done or error, err_code and the core_rst change are all registered. They take effect in the cycle after the deciding byte's handshake.
- The last payload word's imem_we pulse coincides with the cycle in which the checksum byte can be accepted at the earliest. Both events proceed independently.
- Reset mid-operation asserts asynchronously and aborts immediately:
  - imem_we drops to 0 at once.
  - core_rst returns to 1.
  - All counters clear.
  - A partial word is discarded and never written.
- in_valid gaps of any length inside the frame change nothing except the timing of the writes.

## Test plan
- Two-word image, DEPTH=256:
  - Stimulus: bytes 02 00, 13 00 00 00, 93 00 10 00, checksum 90.
  - Required: writes (addr 0x0, data 0x00000013) and (addr 0x4, data 0x00100093); done = 1, core_rst = 0, words_loaded = 2, err_code = 00.
- Zero-size image:
  - Stimulus: header 00 00.
  - Required: error = 1, err_code = 01, no imem_we pulse, core_rst stays 1, in_ready = 0 from then on.
- Oversize image, DEPTH=256:
  - Stimulus: header 01 01 (N = 257).
  - Required: err_code = 10 in the cycle after the second byte; no writes.
- Bad checksum:
  - Stimulus: the two-word image above with checksum byte 91.
  - Required: both writes occur, then error = 1, err_code = 11, core_rst = 1, done = 0.
- Random stalls:
  - Stimulus: the two-word image with random in_valid gaps of 0-5 cycles.
  - Required: write addresses, write data and final outputs identical to the first scenario; each imem_we lasts exactly one cycle.
- Reset mid-load:
  - Stimulus: pulse rst low after 5 payload bytes of the first scenario, then replay the full frame.
  - Required: at reset all outputs return to their reset values immediately and the partial word is never written; the replay completes exactly as in the first scenario.
